// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_e       : converter FSM encoding (IDLE=0, CONV=1, DONE=2)
//   bcd_w()       : packed BCD input width for a given binary result width
//   ndig()        : number of 4-bit digits in the internal digit register
//   ADJ_THRESH/SUB: per-digit correction applied after each right shift
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // A digit that reaches 8 after a right shift came from an odd upper digit
    // (worth 10/2 = 5 rather than 8), so 3 is taken away.
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    function automatic int unsigned bcd_w(input int unsigned bits);
        return bits + (bits - 4) / 3 + 1;
    endfunction

    function automatic int unsigned ndig(input int unsigned bits);
        return (bcd_w(bits) + 3) / 4;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step for reverse double-dabble.
//   din  : 4-bit digit after the shift
//   dout : din - 3 when din >= 8, else din (4-bit modulo, no carry out)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din - ADJ_SUB;
        end
    end

endmodule

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit
// per clock). A conversion takes BITS iterations; done pulses for one cycle
// and bin/err are held until the next result.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request a conversion of bcd (ignored while busy)
//   bcd   : packed BCD input, least significant digit in [3:0]
//   busy  : conversion in progress
//   done  : one-cycle pulse, bin/err valid
//   bin   : binary result, forced to 0 on error
//   err   : invalid digit in input or value above 2**BITS-1
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int unsigned BITS = 9,
    localparam int unsigned BCD_W = bcd_w(BITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd,
    output logic             busy,
    output logic             done,
    output logic [BITS-1:0]  bin,
    output logic             err
);

    localparam int unsigned NDIG  = ndig(BITS);
    localparam int unsigned DW    = NDIG * 4;
    localparam int unsigned CNT_W = $clog2(BITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS - 1);

    state_e             state_q;
    logic [DW-1:0]      digits_q;
    logic [BITS-1:0]    shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               invalid_q;
    logic               busy_q;
    logic               done_q;
    logic [BITS-1:0]    bin_q;
    logic               err_q;

    logic [DW-1:0]      bcd_ext;
    logic               invalid_in;
    logic [DW+BITS-1:0] shifted;
    logic [DW-1:0]      adj_digits;
    logic               overflow;

    assign bcd_ext = DW'(bcd);

    always_comb begin
        invalid_in = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_ext[4*i +: 4] > 4'd9) begin
                invalid_in = 1'b1;
            end
        end
    end

    // One iteration: shift the whole {digits, shift} chain right, then
    // correct each digit independently.
    assign shifted = {digits_q, shift_q} >> 1;

    for (genvar g = 0; g < int'(NDIG); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (shifted[BITS + 4*g +: 4]),
            .dout (adj_digits[4*g +: 4])
        );
    end

    // Anything left in the digit register after the last shift means the
    // value did not fit in BITS bits.
    assign overflow = |adj_digits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= CONV;
                        busy_q    <= 1'b1;
                        digits_q  <= bcd_ext;
                        shift_q   <= '0;
                        cnt_q     <= '0;
                        invalid_q <= invalid_in;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CONV: begin
                    digits_q <= adj_digits;
                    shift_q  <= shifted[BITS-1:0];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= invalid_q | overflow;
                        bin_q   <= (invalid_q | overflow) ? '0 : shifted[BITS-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bin  = bin_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
module tb_bcd2bin;

    localparam int unsigned BITS  = 9;
    localparam int unsigned BCD_W = 11;
    localparam int          LAT   = BITS + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BCD_W-1:0] bcd = '0;
    logic             busy;
    logic             done;
    logic [BITS-1:0]  bin;
    logic             err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    bcd2bin #(.BITS(BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the nibbles, validity and range by plain arithmetic.
    task automatic model(input logic [BCD_W-1:0] b, output logic [BITS-1:0] eb,
                         output logic ee);
        int v;
        int p;
        int n;
        logic inv;
        v = 0;
        p = 1;
        inv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n = int'((b >> (4 * i)) & 11'hF);
            if (n > 9) inv = 1'b1;
            v += n * p;
            p *= 10;
        end
        ee = inv || (v > 511);
        eb = ee ? '0 : BITS'(v);
    endtask

    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        return BCD_W'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    // Called at the first negedge after the accepting edge; returns at the
    // negedge where done is seen, with lat = edges counted from acceptance.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            check("busy_in_conv", busy, 1);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            lat = 0;
        end else begin
            check("busy_with_done", busy, 0);
        end
    endtask

    task automatic do_conv(input logic [BCD_W-1:0] v, input bit hold, output int lat);
        @(negedge clk);
        start = 1'b1;
        bcd = v;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            bcd = 11'h123;
        end else begin
            start = 1'b0;
            bcd = BCD_W'($urandom);
        end
        wait_done(lat);
        start = 1'b0;
    endtask

    task automatic conv_check(input string tag, input logic [BCD_W-1:0] v);
        int lat;
        logic [BITS-1:0] eb;
        logic ee;
        model(v, eb, ee);
        do_conv(v, 1'b0, lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_bin"}, bin, eb);
        check({tag, "_err"}, err, ee);
    endtask

    initial begin
        int lat;
        int snap;
        logic [BITS-1:0] eb;
        logic ee;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bin", bin, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        conv_check("zero", 11'h000);
        conv_check("v511", 11'h511);
        conv_check("v255", 11'h255);
        conv_check("invalid", 11'h0A0);
        conv_check("overflow", 11'h512);

        // start held through CONV with bcd changing under it
        do_conv(11'h255, 1'b1, lat);
        check("hold_lat", lat, LAT);
        check("hold_bin", bin, 255);
        check("hold_err", err, 0);

        // back-to-back: new start in the DONE cycle
        conv_check("b2b_first", 11'h511);
        start = 1'b1;
        bcd = 11'h037;
        check("b2b_held_bin", bin, 511);
        check("b2b_held_err", err, 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("b2b_lat", lat, LAT);
        check("b2b_bin", bin, 37);
        check("b2b_err", err, 0);

        // reset during CONV
        conv_check("pre_rst", 11'h511);
        @(negedge clk);
        start = 1'b1;
        bcd = 11'h300;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_bin", bin, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        snap = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_rst", done_cnt - snap, 0);
        conv_check("post_rst", 11'h511);

        // random encodings, including invalid nibbles and overflow
        for (int i = 0; i < 150; i++) begin
            logic [BCD_W-1:0] r;
            r = BCD_W'($urandom_range(0, 2047));
            conv_check("rand", r);
        end

        // every representable value
        @(negedge clk);
        snap = done_cnt;
        for (int v = 0; v < 512; v++) begin
            do_conv(to_bcd(v), 1'b0, lat);
            model(to_bcd(v), eb, ee);
            check("exh_lat", lat, LAT);
            check("exh_bin", bin, v);
            check("exh_model", {31'd0, ee}, 0);
            check("exh_err", err, 0);
        end
        @(negedge clk);
        check("exh_done_count", done_cnt - snap, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 SHALL have parameter BITS, default 9: width of the binary result; legal range 4..32.
REQ-002 SHALL use derived constant BCD_W = BITS + (BITS-4)/3 + 1: packed BCD input width.
REQ-003 SHALL use derived constant NDIG = ceil(BCD_W/4): number of internal 4-bit digits, with the top digit zero-padded.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request conversion of bcd; sampled on clk.
REQ-007 SHALL have port bcd, input, BCD_W bits: packed BCD value, least significant digit in [3:0]; sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; result and err are valid.
REQ-010 SHALL have port bin, output, BITS bits: binary result, held from done until the next accepted start.
REQ-011 SHALL have port err, output, 1 bit: invalid digit or overflow; valid with done and held with bin.

Function
REQ-012 SHALL implement FSM states IDLE, CONV and DONE.
REQ-013 SHALL make transitions IDLE->CONV on start, CONV->DONE after the BITS-th iteration, DONE->CONV on start, and DONE->IDLE otherwise.
REQ-014 SHALL accept start only in IDLE or DONE; start in CONV SHALL be ignored, with no effect on the result.
REQ-015 On accept, SHALL load the zero-extended bcd into an NDIG*4-bit digit register, clear the BITS-bit shift register, clear the iteration counter, and latch invalid = any nibble > 9.
REQ-016 Each CONV cycle SHALL shift {digits, shift} right by one bit, then subtract 3 from every digit >= 8, all in the same cycle.
REQ-017 SHALL complete exactly BITS iterations: start accepted at edge N gives done=1 in the cycle following edge N+BITS, so latency is BITS+1 edges.
REQ-018 SHALL set overflow = (digit register != 0) after the final iteration, meaning the input exceeds 2**BITS-1.
REQ-019 SHALL drive err = invalid | overflow, registered into DONE.
REQ-020 SHALL force bin = 0 when err = 1; otherwise bin SHALL equal the shift register.
REQ-021 SHALL hold busy = 1 exactly in CONV, and busy and done SHALL never be high together.
REQ-022 A start accepted in the DONE cycle SHALL begin a new conversion with no gap, while bin and err still show the previous result during that cycle.
REQ-023 The iteration counter SHALL be $clog2(BITS+1) bits wide and SHALL not wrap within one conversion.
REQ-024 All arithmetic SHALL be unsigned, and the digit adjust SHALL be 4-bit modulo with no carry between digits.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE and set busy=0, done=0, bin=0, err=0, and clear all internal registers, independent of clk.
REQ-026 Reset mid-conversion SHALL abort the conversion, and no done SHALL follow.
REQ-027 After rst_n deasserts, the first accepted start SHALL behave exactly as after power-up.

Structure
REQ-028 A shared package bcd_pkg SHALL hold the state encoding (IDLE=0, CONV=1, DONE=2), the BCD_W/NDIG width functions, and the digit-adjust constants 8 and 3.
REQ-029 SHALL use one sub-module, bcd_digit_adj: a combinational 4-bit digit-in to digit-out (>=8 subtract 3) block, instantiated NDIG times via generate.
REQ-030 All outputs SHALL be registered, with no combinational path from start or bcd to outputs.

Verification (BITS=9, BCD_W=11)
REQ-031 Bench SHALL check: reset, then start with bcd=11'h000 -> done exactly 10 edges later, bin=0, err=0.
REQ-032 Bench SHALL check: bcd=11'h511 -> bin=511, err=0; bcd=11'h255 -> bin=255, err=0.
REQ-033 Bench SHALL check: bcd=11'h0A0 (invalid digit) -> done, err=1, bin=0; bcd=11'h512 (overflow) -> err=1, bin=0.
REQ-034 Bench SHALL check: start held through CONV with bcd changed to 11'h123 mid-conversion -> result still matches the first accepted value; start in the DONE cycle -> next done 10 edges later.
REQ-035 Bench SHALL check: rst_n pulsed low during CONV -> busy, done, bin and err go to 0 immediately, with no done pulse afterwards.
REQ-036 Bench SHALL run exhaustively over all values 0..511 encoded as BCD, checking bin equals the value with err=0, and checking a done count of 512.
